stpw_ascii_tx: RTL



---
 rtl/stpw_ascii_pkg.sv | 28 ++
 rtl/stpw_ascii_tx_bin2ascii2.sv | 21 ++
 rtl/stpw_ascii_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/stpw_ascii_pkg.sv
// Shared constants for the stopwatch time-to-ASCII serializer.
// Includes ASCII codes, frame lengths, time-word field layout and FSM states.
package stpw_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int unsigned FRAME_LEN_CRLF = 13;
    localparam int unsigned FRAME_LEN      = 11;

    // Field layout of the packed 24-bit time word {hour, min, sec, msec}.
    localparam int unsigned HOUR_LSB = 19;
    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MIN_LSB  = 13;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned SEC_LSB  = 7;
    localparam int unsigned SEC_W    = 6;
    localparam int unsigned MSEC_LSB = 0;
    localparam int unsigned MSEC_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stpw_ascii_tx_bin2ascii2.sv
// Combinational 7-bit binary to two ASCII decimal digits {tens, ones}.
// Values of 100 and above are clamped to 99.
module bin2ascii2
    import stpw_ascii_pkg::*;
(
    input  logic [6:0]  value,
    output logic [15:0] ascii
);

    logic [6:0] sat;
    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        sat   = (value >= 7'd100) ? 7'd99 : value;
        tens  = 4'(sat / 7'd10);
        ones  = 4'(sat % 7'd10);
        ascii = {ASCII_ZERO + {4'b0, tens}, ASCII_ZERO + {4'b0, ones}};
    end

endmodule

// File: rtl/stpw_ascii_tx.sv
// Snapshots the packed time word on start and streams "HH:MM:SS.CC" as bytes.
// Define STPW_ASCII_CRLF_EN to append CR LF (13-byte frame instead of 11).
module stpw_ascii_tx
    import stpw_ascii_pkg::*;
#(
    parameter logic [7:0] SEP_HMS  = 8'h3A,
    parameter logic [7:0] SEP_FRAC = 8'h2E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] time_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        done
);

`ifdef STPW_ASCII_CRLF_EN
    localparam int unsigned LEN = FRAME_LEN_CRLF;
`else
    localparam int unsigned LEN = FRAME_LEN;
`endif
    localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [23:0] snap, snap_nx;
    logic [15:0] hh, mm, ss, cc;
    logic        xfer;

    bin2ascii2 u_hour (.value(7'(snap[HOUR_LSB +: HOUR_W])), .ascii(hh));
    bin2ascii2 u_min  (.value(7'(snap[MIN_LSB  +: MIN_W])),  .ascii(mm));
    bin2ascii2 u_sec  (.value(7'(snap[SEC_LSB  +: SEC_W])),  .ascii(ss));
    bin2ascii2 u_msec (.value(7'(snap[MSEC_LSB +: MSEC_W])), .ascii(cc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= 4'd0;
            snap  <= 24'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            snap  <= snap_nx;
        end
    end

    assign xfer = tx_valid & tx_ready;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        snap_nx  = snap;
        case (state)
            // DONE also samples start so frames can run back-to-back.
            ST_IDLE, ST_DONE: begin
                state_nx = ST_IDLE;
                if (start) begin
                    snap_nx  = time_data;
                    idx_nx   = 4'd0;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        idx_nx   = 4'd0;
                        state_nx = ST_DONE;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign tx_valid = (state == ST_SEND);
    assign busy     = (state == ST_SEND);
    assign done     = (state == ST_DONE);

    // Byte only changes with idx, so it is stable while waiting for ready.
    always_comb begin
        tx_byte = 8'h00;
        if (state == ST_SEND) begin
            case (idx)
                4'd0:    tx_byte = hh[15:8];
                4'd1:    tx_byte = hh[7:0];
                4'd2:    tx_byte = SEP_HMS;
                4'd3:    tx_byte = mm[15:8];
                4'd4:    tx_byte = mm[7:0];
                4'd5:    tx_byte = SEP_HMS;
                4'd6:    tx_byte = ss[15:8];
                4'd7:    tx_byte = ss[7:0];
                4'd8:    tx_byte = SEP_FRAC;
                4'd9:    tx_byte = cc[15:8];
                4'd10:   tx_byte = cc[7:0];
`ifdef STPW_ASCII_CRLF_EN
                4'd11:   tx_byte = ASCII_CR;
                4'd12:   tx_byte = ASCII_LF;
`endif
                default: tx_byte = 8'h00;
            endcase
        end
    end

endmodule
